jtag_seq_packer: RTL and testbench

Assembles the byte stream from the MCU host interface into 32-bit JTAG sequence entries and buffers them in a first-word-fall-through FIFO. Its `out_seq_*` port drives the `out_seq_*` inputs of the JTAG controller directly. The block is agnostic to command meaning: WR, STORE payload, EXECUTE and FLUSH entries all pass through unchanged and in order.

---
 rtl/jtag_seq_packer.sv | 179 +++++++++++++++++
 tb/tb_jtag_seq_packer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_seq_packer.sv
// Packs the host byte stream into 32-bit JTAG sequence entries and queues
// them in a first-word-fall-through FIFO that feeds the JTAG controller.

package jtag_seq_packer_pkg;

    typedef struct packed {
        logic [2:0] bits;
        logic [4:0] command;
        logic [7:0] tms;
        logic [7:0] tdi;
        logic [7:0] read;
    } seq_entry_t;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_TMS  = 2'd1,
        S_TDI  = 2'd2,
        S_READ = 2'd3
    } asm_state_e;

endpackage

module jtag_seq_packer
    import jtag_seq_packer_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_first,
    output logic              in_ready,
    output logic              out_seq_empty,
    output logic [4:0]        out_seq_command,
    output logic [2:0]        out_seq_bits,
    output logic [7:0]        out_seq_tms,
    output logic [7:0]        out_seq_tdi,
    output logic [7:0]        out_seq_read,
    input  logic              out_seq_re,
    output logic [ADDR_W:0]   level,
    output logic [7:0]        resync_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LVL_W = ADDR_W + 1;

    asm_state_e        state_q, state_d;
    logic [7:0]        hdr_q, hdr_d;
    logic [7:0]        tms_q, tms_d;
    logic [7:0]        tdi_q, tdi_d;
    logic              accept;
    logic              wr_en;
    logic              resync_inc;
    seq_entry_t        wr_word;

    seq_entry_t        ram [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    seq_entry_t        out_q;
    logic              out_valid;
    logic [LVL_W-1:0]  ram_cnt;
    logic              pop;
    logic              load;

    // Only the final byte can stall; it depends on registered state alone.
    always_comb begin
        in_ready = (state_q != S_READ) || (level < LVL_W'(DEPTH));
    end

    assign accept  = in_valid && in_ready && !clear;
    assign wr_word = '{bits: hdr_q[7:5], command: hdr_q[4:0],
                       tms: tms_q, tdi: tdi_q, read: in_data};

    // Assembler state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR;
            hdr_q   <= 8'd0;
            tms_q   <= 8'd0;
            tdi_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end

    // Assembler next state: a header always restarts the entry
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        wr_en      = 1'b0;
        resync_inc = 1'b0;
        if (clear) begin
            state_d = S_HDR;
        end else if (accept) begin
            if (in_first) begin
                hdr_d      = in_data;
                state_d    = S_TMS;
                resync_inc = (state_q != S_HDR);
            end else begin
                unique case (state_q)
                    S_HDR: resync_inc = 1'b1;
                    S_TMS: begin
                        tms_d   = in_data;
                        state_d = S_TDI;
                    end
                    S_TDI: begin
                        tdi_d   = in_data;
                        state_d = S_READ;
                    end
                    S_READ: begin
                        wr_en   = 1'b1;
                        state_d = S_HDR;
                    end
                endcase
            end
        end
    end

    // Saturating count of discarded partial entries; survives clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resync_cnt <= 8'd0;
        end else if (resync_inc && (resync_cnt != 8'hFF)) begin
            resync_cnt <= resync_cnt + 8'd1;
        end
    end

    // RAM holds entries not yet moved into the output register
    assign ram_cnt   = level - LVL_W'(out_valid);
    assign out_valid = !out_seq_empty;
    assign pop       = out_seq_re && out_valid && !clear;
    assign load      = (!out_valid || pop) && (ram_cnt != '0) && !clear;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr] <= wr_word;
        end
    end

    // Pointers, occupancy and the fall-through output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            out_seq_empty <= 1'b1;
            out_q         <= '0;
        end else if (clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            out_seq_empty <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                out_q  <= ram[rd_ptr];
            end
            out_seq_empty <= !(load || (out_valid && !pop));
            level         <= level + LVL_W'(wr_en) - LVL_W'(pop);
        end
    end

    assign out_seq_command = out_q.command;
    assign out_seq_bits    = out_q.bits;
    assign out_seq_tms     = out_q.tms;
    assign out_seq_tdi     = out_q.tdi;
    assign out_seq_read    = out_q.read;

endmodule

// File: tb/tb_jtag_seq_packer.sv
// Self-checking bench for jtag_seq_packer against a queue-based model of the
// host byte protocol, the entry FIFO and its presentation latency.

module tb_jtag_seq_packer;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_first;
    logic        in_ready;
    logic        out_seq_empty;
    logic [4:0]  out_seq_command;
    logic [2:0]  out_seq_bits;
    logic [7:0]  out_seq_tms;
    logic [7:0]  out_seq_tdi;
    logic [7:0]  out_seq_read;
    logic        out_seq_re;
    logic [AW:0] level;
    logic [7:0]  resync_cnt;

    jtag_seq_packer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_first(in_first),
        .in_ready(in_ready), .out_seq_empty(out_seq_empty),
        .out_seq_command(out_seq_command), .out_seq_bits(out_seq_bits),
        .out_seq_tms(out_seq_tms), .out_seq_tdi(out_seq_tdi),
        .out_seq_read(out_seq_read), .out_seq_re(out_seq_re),
        .level(level), .resync_cnt(resync_cnt)
    );

    always #5 clk = ~clk;

    // Model: an entry becomes visible once it has sat in the FIFO for one edge
    typedef struct {
        logic [31:0] word;
        int          wr;
    } ent_t;

    ent_t       q[$];
    int         m_idx;
    logic [7:0] m_hdr, m_tms, m_tdi;
    int         m_resync;
    int         cyc;
    int         checks;
    int         errors;

    function automatic bit m_vis();
        return (q.size() > 0) && (q[0].wr < cyc);
    endfunction

    function automatic bit m_ready();
        return (m_idx != 3) || (q.size() < DEPTH);
    endfunction

    function automatic logic [31:0] dut_word();
        return {out_seq_bits, out_seq_command, out_seq_tms, out_seq_tdi, out_seq_read};
    endfunction

    function automatic void bump();
        m_resync = (m_resync < 255) ? m_resync + 1 : 255;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_idx    = 0;
        m_resync = 0;
    endfunction

    // One clock cycle of stimulus; advances the model with the same inputs
    task automatic drive(input logic v, input logic [7:0] d, input logic f,
                         input logic re, input logic clr);
        bit acc;
        bit pp;
        in_valid   = v;
        in_data    = d;
        in_first   = f;
        out_seq_re = re;
        clear      = clr;
        acc = v && m_ready() && !clr;
        pp  = re && m_vis() && !clr;
        @(posedge clk);
        cyc++;
        if (clr) begin
            q.delete();
            m_idx = 0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                if (f) begin
                    if (m_idx != 0) bump();
                    m_hdr = d;
                    m_idx = 1;
                end else begin
                    case (m_idx)
                        0: bump();
                        1: begin m_tms = d; m_idx = 2; end
                        2: begin m_tdi = d; m_idx = 3; end
                        default: begin
                            q.push_back('{word: {m_hdr, m_tms, m_tdi, d}, wr: cyc});
                            m_idx = 0;
                        end
                    endcase
                end
            end
        end
        #1;
    endtask

    task automatic send_entry(input logic [7:0] h, input logic [7:0] t,
                              input logic [7:0] di, input logic [7:0] r);
        drive(1'b1, h, 1'b1, 1'b0, 1'b0);
        drive(1'b1, t, 1'b0, 1'b0, 1'b0);
        drive(1'b1, di, 1'b0, 1'b0, 1'b0);
        drive(1'b1, r, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; out_seq_re = 1'b0; clear = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        // Power-on reset values
        checks++;
        if ({in_ready, out_seq_empty, level, resync_cnt, dut_word()} !== {1'b1, 1'b1, 3'd0, 8'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_pon: got rdy=%b empty=%b level=%0d resync=%0d word=%h", in_ready, out_seq_empty, level, resync_cnt, dut_word());
        end
        rst = 1'b1;
        // Mid-stream: one entry presented, a partial one pending, a pop in flight
        send_entry(8'h23, 8'h01, 8'h02, 8'h03);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h45, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h46, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h47; in_first = 1'b0; out_seq_re = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_seq_empty, level, resync_cnt, dut_word()} !== {1'b1, 1'b1, 3'd0, 8'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_async: got rdy=%b empty=%b level=%0d resync=%0d word=%h", in_ready, out_seq_empty, level, resync_cnt, dut_word());
        end
        model_reset();
        in_valid = 1'b0; out_seq_re = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
        send_entry(8'h62, 8'h5A, 8'hC3, 8'h0F);
        checks++;
        if (out_seq_empty !== 1'b1 || level !== 3'd1) begin
            errors++;
            $display("FAIL reset_lat1: got empty=%b level=%0d want empty=1 level=1", out_seq_empty, level);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_seq_empty !== 1'b0 || dut_word() !== 32'h625AC30F) begin
            errors++;
            $display("FAIL reset_lat2: got empty=%b word=%h want empty=0 word=625ac30f", out_seq_empty, dut_word());
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_single();
        send_entry(8'h21, 8'hA5, 8'h3C, 8'h01);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out_seq_empty, out_seq_command, out_seq_bits, out_seq_tms, out_seq_tdi, out_seq_read, level}
            !== {1'b0, 5'h01, 3'd1, 8'hA5, 8'h3C, 8'h01, 3'd1}) begin
            errors++;
            $display("FAIL single_fields: got empty=%b cmd=%h bits=%0d tms=%h tdi=%h read=%h level=%0d",
                     out_seq_empty, out_seq_command, out_seq_bits, out_seq_tms, out_seq_tdi, out_seq_read, level);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_seq_empty !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("FAIL single_pop: got empty=%b level=%0d want empty=1 level=0", out_seq_empty, level);
        end
    endtask

    task automatic test_fill_full();
        logic [7:0] exp_tms [4];
        for (int k = 0; k < 4; k++) send_entry(8'h40 | 8'(k), 8'h10 + 8'(k), 8'(k), 8'(k));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (level !== 3'd4 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_level: got level=%0d rdy=%b want level=4 rdy=1", level, in_ready);
        end
        drive(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h14, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: got rdy=%b want 0", in_ready);
        end
        drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || level !== 3'd4) begin
            errors++;
            $display("FAIL full_hold: got rdy=%b level=%0d want rdy=0 level=4", in_ready, level);
        end
        drive(1'b1, 8'h04, 1'b0, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || level !== 3'd3) begin
            errors++;
            $display("FAIL full_pop: got rdy=%b level=%0d want rdy=1 level=3", in_ready, level);
        end
        drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
        checks++;
        if (level !== 3'd4 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_refill: got level=%0d rdy=%b want level=4 rdy=1", level, in_ready);
        end
        exp_tms = '{8'h11, 8'h12, 8'h13, 8'h14};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_seq_empty !== 1'b0 || out_seq_tms !== exp_tms[i]) begin
                errors++;
                $display("FAIL full_drain%0d: got empty=%b tms=%h want tms=%h", i, out_seq_empty, out_seq_tms, exp_tms[i]);
            end
            drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        for (int c = 0; c < 60; c++) begin
            if (!out_seq_empty) got.push_back(out_seq_tms);
            if (c < 40)
                drive(1'b1, (c % 4 == 0) ? 8'(c / 4) | 8'h80 : 8'(c / 4), (c % 4 == 0), 1'b1, 1'b0);
            else
                drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (got.size() != 10) begin
            errors++;
            $display("FAIL wrap_count: got %0d entries want 10", got.size());
        end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            checks++;
            if (got[i] !== 8'(i)) begin
                errors++;
                $display("FAIL wrap_order%0d: got tms=%h want %h", i, got[i], 8'(i));
            end
        end
    endtask

    task automatic test_resync();
        drive(1'b1, 8'h45, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        send_entry(8'h46, 8'h11, 8'h22, 8'h33);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (resync_cnt !== 8'd1 || level !== 3'd1 || dut_word() !== 32'h46112233) begin
            errors++;
            $display("FAIL resync_hdr: got resync=%0d level=%0d word=%h want 1/1/46112233", resync_cnt, level, dut_word());
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        checks++;
        if (resync_cnt !== 8'd2 || level !== 3'd0) begin
            errors++;
            $display("FAIL resync_stray: got resync=%0d level=%0d want 2/0", resync_cnt, level);
        end
        for (int i = 0; i < 300; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (resync_cnt !== 8'd255) begin
            errors++;
            $display("FAIL resync_sat: got %0d want 255", resync_cnt);
        end
    endtask

    task automatic test_clear();
        for (int k = 0; k < 3; k++) send_entry(8'h20 | 8'(k), 8'(k), 8'(k), 8'(k));
        checks++;
        if (level !== 3'd3) begin
            errors++;
            $display("FAIL clear_pre: got level=%0d want 3", level);
        end
        drive(1'b1, 8'h23, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
        checks++;
        if (level !== 3'd0 || out_seq_empty !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_now: got level=%0d empty=%b rdy=%b want 0/1/1", level, out_seq_empty, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            checks++;
            if (out_seq_empty !== 1'b1 || level !== 3'd0) begin
                errors++;
                $display("FAIL clear_idle%0d: got empty=%b level=%0d want 1/0", i, out_seq_empty, level);
            end
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (level !== 3'd0 || out_seq_empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_idx: got level=%0d empty=%b want 0/1", level, out_seq_empty);
        end
    endtask

    task automatic test_random();
        int  pos;
        bit  v, f, re, clr, nat;
        logic [7:0] d;
        do_reset();
        pos = 0;
        for (int c = 0; c < 1500; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            nat = (pos == 0);
            f   = ($urandom_range(0, 15) == 0) ? !nat : nat;
            d   = 8'($urandom);
            re  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 99) == 0);
            checks++;
            if (in_ready !== m_ready()) begin
                errors++;
                $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, m_ready());
            end
            if (v && m_ready() && !clr) pos = f ? 1 : ((pos == 0) ? 0 : (pos + 1) % 4);
            if (clr) pos = 0;
            drive(v, d, f, re, clr);
            checks++;
            if (out_seq_empty !== !m_vis() || level !== 3'(q.size()) || resync_cnt !== 8'(m_resync)) begin
                errors++;
                $display("FAIL rand_state c=%0d: got empty=%b level=%0d resync=%0d want %b/%0d/%0d",
                         c, out_seq_empty, level, resync_cnt, !m_vis(), q.size(), m_resync);
            end
            if (m_vis()) begin
                checks++;
                if (dut_word() !== q[0].word) begin
                    errors++;
                    $display("FAIL rand_word c=%0d: got %h want %h", c, dut_word(), q[0].word);
                end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_first = 1'b0; out_seq_re = 1'b0;
        model_reset();
        m_hdr = 8'h00; m_tms = 8'h00; m_tdi = 8'h00;
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        test_reset();
        test_single();
        test_fill_full();
        test_back_to_back();
        test_resync();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
